// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Wait-stated data memory behind the MEM stage of the five-stage pipeline.
//   Each load or store is latched in IDLE, held for WAIT_CYCLES wait states,
//   and completed in DONE. The pipeline freezes its stage registers while
//   ready is low.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   mem_r_en     : load request
//   mem_w_en     : store request (takes priority when both are set)
//   address      : byte address, held stable while ready is low
//   w_data       : store data, held stable with address
//   r_data       : load result, registered, held until the next completed load
//   ready        : access complete, or no request pending
//   access_count : number of completed accesses, wraps at 16 bits
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; a request is latched here
// WAIT   | wait states counting down on cnt_q
// DONE   | access completes; store commits and count bumps on exit

module data_mem_ctrl #(
    parameter int unsigned WORDS       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        ready,
    output logic [15:0] access_count
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               is_write_q, is_write_d;
    logic [31:0]        r_data_q, r_data_d;
    logic [15:0]        count_q, count_d;

    logic [31:0]        mem [WORDS];

    logic               req;
    logic [31:0]        addr_off;
    logic [IDX_W-1:0]   req_idx;
    logic               unused_off_bits;

    assign req = mem_r_en | mem_w_en;

    // Wrapping subtraction; the index is taken modulo WORDS, so
    // out-of-range addresses alias and the byte offset is dropped.
    assign addr_off        = address - BASE;
    assign req_idx         = addr_off[IDX_W+1:2];
    assign unused_off_bits = ^{addr_off[31:IDX_W+2], addr_off[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        r_data_d   = r_data_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d      = req_idx;
                    wdata_d    = w_data;
                    is_write_d = mem_w_en;
                    if (WAIT_INIT == 3'd0) begin
                        // Zero wait states: DONE is entered straight from
                        // IDLE, so the load uses the live request.
                        state_d = S_DONE;
                        if (!mem_w_en) begin
                            r_data_d = mem[req_idx];
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    if (!is_write_q) begin
                        r_data_d = mem[idx_q];
                    end
                end
            end
            S_DONE: begin
                count_d = count_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            r_data_q   <= 32'd0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            r_data_q   <= r_data_d;
            count_q    <= count_d;
        end
    end

    // Storage is not reset. A reset during DONE forces IDLE before the
    // next edge, so an interrupted store never commits.
    always_ff @(posedge clk) begin
        if (state_q == S_DONE && is_write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            S_IDLE:  ready = ~req;
            S_WAIT:  ready = 1'b0;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign r_data       = r_data_q;
    assign access_count = count_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with two wait states
    logic        rst2, r_en2, w_en2, ready2;
    logic [31:0] addr2, wd2, r_data2;
    logic [15:0] cnt2;

    // Instance with zero wait states
    logic        rst0, r_en0, w_en0, ready0;
    logic [31:0] addr0, wd0, r_data0;
    logic [15:0] cnt0;

    data_mem_ctrl #(.WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut2 (
        .clk(clk), .rst(rst2), .mem_r_en(r_en2), .mem_w_en(w_en2),
        .address(addr2), .w_data(wd2), .r_data(r_data2), .ready(ready2),
        .access_count(cnt2)
    );

    data_mem_ctrl #(.WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
        .clk(clk), .rst(rst0), .mem_r_en(r_en0), .mem_w_en(w_en0),
        .address(addr0), .w_data(wd0), .r_data(r_data0), .ready(ready0),
        .access_count(cnt0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit z, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            w_en0 = we; r_en0 = re; addr0 = a; wd0 = d;
        end else begin
            w_en2 = we; r_en2 = re; addr2 = a; wd2 = d;
        end
    endtask

    // Starts at negedge+1 in IDLE, returns at negedge+1 of the cycle after DONE.
    // lows = cycles with ready low, rd = r_data seen in the ready-high cycle.
    task automatic access(input bit z, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lows, output logic [31:0] rd);
        logic rdy;
        lows = 0;
        drive(z, we, re, a, d);
        #1;
        rdy = z ? ready0 : ready2;
        while (!rdy && lows < 20) begin
            lows++;
            @(negedge clk); #1;
            rdy = z ? ready0 : ready2;
        end
        if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
        rd = z ? r_data0 : r_data2;
        drive(z, 1'b0, 1'b0, a, d);
        @(negedge clk); #1;
    endtask

    initial begin
        int          lows, total;
        logic [31:0] rd;

        rst2 = 1'b1; rst0 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        @(negedge clk); #1;
        check("rst_ready",   32'(ready2),  32'd1);
        check("rst_rdata",   r_data2,      32'h0);
        check("rst_count",   32'(cnt2),    32'd0);
        r_en2 = 1'b1; #1;
        check("rst_ready_req", 32'(ready2), 32'd0);
        r_en2 = 1'b0;
        @(negedge clk); rst2 = 1'b0; rst0 = 1'b0;
        @(negedge clk); #1;

        // Store then load
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h12345678, lows, rd);
        check("wr_lows", 32'(lows), 32'd3);
        check("wr_count", 32'(cnt2), 32'd1);
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, lows, rd);
        check("rd_lows", 32'(lows), 32'd3);
        check("rd_data", rd, 32'h12345678);
        check("rd_count", 32'(cnt2), 32'd2);

        // Both enables: behaves as a store, r_data untouched
        access(1'b0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lows, rd);
        check("both_rdata_held", r_data2, 32'h12345678);
        access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0, lows, rd);
        check("both_readback", rd, 32'hCAFEF00D);
        check("both_count", 32'(cnt2), 32'd4);

        // Aliasing and misalignment
        access(1'b0, 1'b1, 1'b0, 32'd1280, 32'hA5A5A5A5, lows, rd);
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, lows, rd);
        check("alias_rd", rd, 32'hA5A5A5A5);
        access(1'b0, 1'b1, 1'b0, 32'd1029, 32'h00000007, lows, rd);
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, lows, rd);
        check("misalign_rd", rd, 32'h00000007);
        check("alias_count", 32'(cnt2), 32'd8);

        // Reset in the first WAIT cycle of a store
        access(1'b0, 1'b1, 1'b0, 32'd1036, 32'h00000001, lows, rd);
        drive(1'b0, 1'b1, 1'b0, 32'd1036, 32'hDEADBEEF);
        @(posedge clk); #1;
        rst2 = 1'b1; #1;
        check("midrst_count", 32'(cnt2),   32'd0);
        check("midrst_rdata", r_data2,     32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); rst2 = 1'b0;
        @(negedge clk); #1;
        access(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0, lows, rd);
        check("midrst_rd", rd, 32'h00000001);
        check("midrst_count2", 32'(cnt2), 32'd1);

        // Zero-wait-state instance: ten back-to-back stores
        total = 0;
        for (int i = 0; i < 10; i++) begin
            access(1'b1, 1'b1, 1'b0, 32'(1024 + 4 * i), 32'(32'h100 + i), lows, rd);
            if (i == 0) check("w0_lows", 32'(lows), 32'd1);
            total += lows + 1;
        end
        check("w0_total_cycles", 32'(total), 32'd20);
        check("w0_count", 32'(cnt0), 32'd10);
        access(1'b1, 1'b0, 1'b1, 32'd1044, 32'h0, lows, rd);
        check("w0_rd_lows", 32'(lows), 32'd1);
        check("w0_rd", rd, 32'h105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
